// File: rtl/centroid_steer_ctrl.sv
// Line-follower steering: centroid error -> P(D) correction -> clamped per-wheel PWM.
// Ports: clk, rst (async, active-high), enable, frame_tick, centroid_x, line_valid,
//   line_lost in; pwm_left/right, duty_left/right (active), state, search_dir out.
// Optional macro STEER_DERIV_EN adds a derivative term (KD) to the correction.
module centroid_steer_ctrl #(
  parameter int IMG_W       = 640,
  parameter int PWM_PERIOD  = 1000,
  parameter int BASE_DUTY   = 600,
  parameter int KP          = 1,
  parameter int KP_SHIFT    = 1,
  parameter int LOST_FRAMES = 4,
  parameter int SEARCH_DUTY = 300,
  parameter int KD          = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        frame_tick,
  input  logic [10:0] centroid_x,
  input  logic        line_valid,
  input  logic        line_lost,
  output logic        pwm_left,
  output logic        pwm_right,
  output logic [10:0] duty_left,
  output logic [10:0] duty_right,
  output logic [1:0]  state,
  output logic        search_dir
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    HOLD   = 2'd2,
    SEARCH = 2'd3
  } st_t;

  if (KP > 255 || KD > 255 || PWM_PERIOD > 2047 ||
      LOST_FRAMES < 1 || LOST_FRAMES > 15) begin : g_bad_cfg
    $error("centroid_steer_ctrl: parameter out of range");
  end

  localparam logic [10:0] LAST = 11'(PWM_PERIOD - 1);
  localparam logic [3:0]  LMAX = 4'(LOST_FRAMES);

  st_t         st, st_n;
  logic [3:0]  lost_cnt, cnt_n;
  logic        good, smp;

  assign good  = line_valid & ~line_lost;
  assign smp   = enable & frame_tick;
  assign state = st;

  // error and product (stage-1 operand)
  logic signed [11:0] err;
  logic signed [23:0] err_x, kp_s, prod;

  assign err   = 12'({1'b0, centroid_x}) - 12'(IMG_W / 2);
  assign err_x = {{12{err[11]}}, err};
  assign kp_s  = 24'(KP);

`ifdef STEER_DERIV_EN
  logic signed [11:0] prev_err;
  logic signed [23:0] prev_x, kd_s;
  assign prev_x = {{12{prev_err[11]}}, prev_err};
  assign kd_s   = 24'(KD);
  assign prod   = (err_x * kp_s) + ((err_x - prev_x) * kd_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      prev_err <= '0;
    else if ((st_n == IDLE && st != IDLE) ||
             (st_n == SEARCH && st != SEARCH))
      prev_err <= '0;
    else if (smp && good)
      prev_err <= err;
  end
`else
  assign prod = err_x * kp_s;
`endif

  // FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      lost_cnt <= '0;
    end else begin
      st       <= st_n;
      lost_cnt <= cnt_n;
    end
  end

  always_comb begin
    st_n  = st;
    cnt_n = lost_cnt;
    if (!enable) begin
      st_n  = IDLE;
      cnt_n = '0;
    end else if (frame_tick) begin
      if (good) begin
        st_n  = TRACK;
        cnt_n = '0;
      end else begin
        unique case (st)
          TRACK, HOLD: begin
            cnt_n = (lost_cnt >= LMAX) ? LMAX : lost_cnt + 4'd1;
            st_n  = (cnt_n == LMAX) ? SEARCH : HOLD;
          end
          SEARCH:  cnt_n = LMAX;
          default: cnt_n = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      search_dir <= 1'b0;
    else if (smp && good)
      search_dir <= ~err[11];
  end

  // stage 1: any new tick restarts the pipe
  logic               s1_vld;
  logic signed [23:0] s1_prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_prod <= '0;
    end else begin
      s1_vld <= smp & good;
      if (smp && good)
        s1_prod <= prod;
    end
  end

  // stage 2: clamp into shadow
  function automatic logic [10:0] clampd(input logic signed [25:0] v);
    if (v < 0)
      return 11'd0;
    else if (v > $signed(26'(PWM_PERIOD)))
      return 11'(PWM_PERIOD);
    else
      return v[10:0];
  endfunction

  logic signed [23:0] sh;
  logic signed [25:0] corr, l_sum, r_sum;
  logic [10:0]        sh_l, sh_r;
  logic               clr, srch, load;

  assign sh    = s1_prod >>> KP_SHIFT;
  assign corr  = {{2{sh[23]}}, sh};
  assign l_sum = 26'(BASE_DUTY) + corr;
  assign r_sum = 26'(BASE_DUTY) - corr;

  assign clr  = ~enable | (st == IDLE);
  assign srch = ~clr & (st == SEARCH);
  assign load = ~clr & (st != SEARCH) & s1_vld & ~frame_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_l <= '0;
      sh_r <= '0;
    end else begin
      unique case (1'b1)
        clr: begin
          sh_l <= '0;
          sh_r <= '0;
        end
        srch: begin
          sh_l <= search_dir ? 11'(SEARCH_DUTY) : 11'd0;
          sh_r <= search_dir ? 11'd0 : 11'(SEARCH_DUTY);
        end
        load: begin
          sh_l <= clampd(l_sum);
          sh_r <= clampd(r_sum);
        end
        default: ;
      endcase
    end
  end

  // PWM: outputs registered from next-state values so
  // pwm_x always equals (counter < active_x)
  logic [10:0] cnt, cnt_nx, act_l_nx, act_r_nx;

  assign cnt_nx   = (cnt == LAST) ? 11'd0 : cnt + 11'd1;
  assign act_l_nx = !enable ? 11'd0 : (cnt == LAST) ? sh_l : duty_left;
  assign act_r_nx = !enable ? 11'd0 : (cnt == LAST) ? sh_r : duty_right;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      duty_left  <= '0;
      duty_right <= '0;
      pwm_left   <= 1'b0;
      pwm_right  <= 1'b0;
    end else begin
      cnt        <= cnt_nx;
      duty_left  <= act_l_nx;
      duty_right <= act_r_nx;
      pwm_left   <= cnt_nx < act_l_nx;
      pwm_right  <= cnt_nx < act_r_nx;
    end
  end

endmodule

// File: tb/tb_centroid_steer_ctrl.sv
// Directed bench for centroid_steer_ctrl (default parameters).
// Expected duties are hand-derived from the steering equations.
module tb_centroid_steer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        frame_tick = 1'b0;
  logic [10:0] centroid_x = '0;
  logic        line_valid = 1'b0;
  logic        line_lost = 1'b0;
  logic        pwm_left, pwm_right;
  logic [10:0] duty_left, duty_right;
  logic [1:0]  state;
  logic        search_dir;

  int compared = 0;
  int mismatched = 0;
  int mcnt = 0;

  always #5 clk = ~clk;

  centroid_steer_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable),
    .frame_tick(frame_tick), .centroid_x(centroid_x),
    .line_valid(line_valid), .line_lost(line_lost),
    .pwm_left(pwm_left), .pwm_right(pwm_right),
    .duty_left(duty_left), .duty_right(duty_right),
    .state(state), .search_dir(search_dir)
  );

  // independent period position: 0..999 from reset release
  always @(posedge clk or posedge rst)
    if (rst) mcnt <= 0;
    else     mcnt <= (mcnt == 999) ? 0 : mcnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic frame(input int cx, input logic v, input logic l);
    @(negedge clk);
    centroid_x = 11'(cx);
    line_valid = v;
    line_lost  = l;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic settle();
    repeat (1003) @(negedge clk);
  endtask

  task automatic duties(input string tag, input int l, input int r);
    chk({tag, "_dl"}, 32'(duty_left), 32'(l));
    chk({tag, "_dr"}, 32'(duty_right), 32'(r));
  endtask

  task automatic highs(input string tag, input int l, input int r);
    int hl = 0;
    int hr = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      hl += int'(pwm_left);
      hr += int'(pwm_right);
    end
    chk({tag, "_hl"}, 32'(hl), 32'(l));
    chk({tag, "_hr"}, 32'(hr), 32'(r));
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    while (mcnt != p && n < 2100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_pos", 32'(mcnt), 32'(p));
  endtask

  initial begin
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_pwml", 32'(pwm_left), 0);
    chk("rst_pwmr", 32'(pwm_right), 0);
    duties("rst", 0, 0);
    chk("rst_sdir", 32'(search_dir), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;

    frame(320, 1, 0);
    chk("trk_state", 32'(state), 1);
    settle();
    duties("c320", 600, 600);
    highs("c320", 600, 600);

    frame(520, 1, 0);
    settle();
    duties("c520", 700, 500);
    chk("c520_sdir", 32'(search_dir), 1);

    frame(0, 1, 0);
    settle();
    duties("c0", 440, 760);
    chk("c0_sdir", 32'(search_dir), 0);

    frame(2047, 1, 0);
    settle();
    duties("c2047", 1000, 0);
    highs("c2047", 1000, 0);

    // err -220, corr -110
    frame(100, 1, 0);
    settle();
    duties("c100", 490, 710);
    frame(0, 0, 1);
    chk("lost1", 32'(state), 2);
    frame(0, 1, 1);
    chk("lost2_both", 32'(state), 2);
    frame(0, 0, 1);
    chk("lost3", 32'(state), 2);
    settle();
    duties("hold", 490, 710);
    frame(0, 0, 1);
    chk("lost4", 32'(state), 3);
    frame(0, 0, 1);
    chk("lost5", 32'(state), 3);
    settle();
    duties("srch_l", 0, 300);
    frame(320, 1, 0);
    chk("recover", 32'(state), 1);
    settle();
    duties("recov", 600, 600);

    // mid-period shadow update
    wait_pos(200);
    centroid_x = 11'd520;
    line_valid = 1'b1;
    line_lost  = 1'b0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    wait_pos(999);
    duties("midper", 600, 600);
    @(negedge clk);
    duties("wrap", 700, 500);

    // disable mid-period
    wait_pos(100);
    chk("pre_dis_pwml", 32'(pwm_left), 1);
    chk("pre_dis_pwmr", 32'(pwm_right), 1);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_pwml", 32'(pwm_left), 0);
    chk("dis_pwmr", 32'(pwm_right), 0);
    chk("dis_state", 32'(state), 0);
    duties("dis", 0, 0);

    // search to the right, then async reset
    enable = 1'b1;
    frame(520, 1, 0);
    repeat (4) frame(0, 0, 1);
    chk("srch2", 32'(state), 3);
    settle();
    duties("srch_r", 300, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst2_state", 32'(state), 0);
    chk("rst2_pwml", 32'(pwm_left), 0);
    chk("rst2_pwmr", 32'(pwm_right), 0);
    duties("rst2", 0, 0);
    chk("rst2_sdir", 32'(search_dir), 0);
    @(negedge clk);
    rst = 1'b0;
    frame(320, 1, 0);
    chk("rst2_trk", 32'(state), 1);
    settle();
    duties("rst2_c320", 600, 600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
